tb_shield_uart_capture: RTL and testbench

- Testbench-side UART receive stage that sits directly downstream of a shield UART pin. It consumes the serial stream the MCU transmits through the Arduino adaptor/shield path.
- Oversamples RXD, frames 8N1 characters and buffers them in a show-ahead FIFO for the bench to drain.
- Counts good and bad frames, and flags an end-of-test character so the bench can finish simulation.

---
 rtl/tb_shield_uart_capture_if.sv | 10 +
 rtl/tb_shield_uart_capture.sv | 176 +++++++++++++++++
 tb/tb_tb_shield_uart_capture.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tb_shield_uart_capture_if.sv
// Read side of the UART capture FIFO: the bench pops, the capture block supplies the head entry.
interface tb_shield_uart_capture_if;
  logic       RD_EN;
  logic [7:0] RD_DATA;
  logic       EMPTY;
  logic       FULL;

  modport master (output RD_EN, input RD_DATA, EMPTY, FULL);
  modport slave  (input RD_EN, output RD_DATA, EMPTY, FULL);
endinterface

// File: rtl/tb_shield_uart_capture.sv
// 8N1 UART receiver for the shield RXD pin, feeding a show-ahead capture FIFO
// with good/bad frame counters and an end-of-test character detector.
module tb_shield_uart_capture #(
  parameter int         CLKS_PER_BIT = 16,
  parameter int         FIFO_DEPTH   = 8,
  parameter logic [7:0] EOT_CHAR     = 8'h04
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic                    RXD,
  tb_shield_uart_capture_if.slave rd,
  output logic                    RX_VALID,
  output logic [7:0]              RX_CHAR,
  output logic                    OVERFLOW,
  output logic [7:0]              FERR_CNT,
  output logic [15:0]             CHAR_CNT,
  output logic                    SIM_END
);
  localparam int TICK_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [PTR_W:0]    DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]    CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  logic [1:0]        sync_reg;
  logic              rxs;
  state_t            state_reg, state_next;
  logic [TICK_W-1:0] tick_reg, tick_next;
  logic [2:0]        bit_reg, bit_next;
  logic [7:0]        shift_reg, shift_next;
  logic              stop_ok, ferr_hit;
  logic              good_pend_reg;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]    count_reg, count_next;
  logic              empty_reg, full_reg;
  logic              push, pop_ok, push_ok;

  logic              rx_valid_reg, sim_end_reg, overflow_reg;
  logic [7:0]        rx_char_reg, ferr_cnt_reg;
  logic [15:0]       char_cnt_reg;

  // RXD is asynchronous to HCLK; only the second stage is ever decoded.
  always_ff @(posedge HCLK) begin
    if (HRESET) sync_reg <= 2'b11;
    else        sync_reg <= {sync_reg[0], RXD};
  end
  assign rxs = sync_reg[1];

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_reg     <= IDLE;
      tick_reg      <= '0;
      bit_reg       <= '0;
      shift_reg     <= '0;
      good_pend_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      tick_reg      <= tick_next;
      bit_reg       <= bit_next;
      shift_reg     <= shift_next;
      good_pend_reg <= stop_ok;
    end
  end

  always_comb begin
    state_next = state_reg;
    tick_next  = tick_reg + TICK_ONE;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    stop_ok    = 1'b0;
    ferr_hit   = 1'b0;
    case (state_reg)
      IDLE: begin
        tick_next = '0;
        if (!rxs) begin
          bit_next   = '0;
          state_next = START;
        end
      end
      START: begin
        if (tick_reg == HALF_LAST) begin
          tick_next  = '0;
          state_next = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick_reg == BIT_LAST) begin
          tick_next  = '0;
          shift_next = {rxs, shift_reg[7:1]};
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (tick_reg == BIT_LAST) begin
          tick_next = '0;
          if (rxs) begin
            stop_ok    = 1'b1;
            state_next = IDLE;
          end else begin
            ferr_hit   = 1'b1;
            state_next = BRK;
          end
        end
      end
      BRK: begin
        tick_next = '0;
        if (rxs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // shift_reg stays stable for a whole bit time after the stop sample,
  // so the deferred good-character actions can read it directly.
  assign push    = good_pend_reg && (shift_reg != EOT_CHAR);
  assign pop_ok  = rd.RD_EN && (count_reg != '0);
  assign push_ok = push && ((count_reg != DEPTH_CNT) || pop_ok);

  always_comb begin
    count_next = count_reg;
    if (push_ok && !pop_ok)      count_next = count_reg + CNT_ONE;
    else if (!push_ok && pop_ok) count_next = count_reg - CNT_ONE;
  end

  always_ff @(posedge HCLK) begin
    if (push_ok) mem[wr_ptr_reg] <= shift_reg;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      empty_reg    <= 1'b1;
      full_reg     <= 1'b0;
      rx_valid_reg <= 1'b0;
      rx_char_reg  <= '0;
      sim_end_reg  <= 1'b0;
      overflow_reg <= 1'b0;
      ferr_cnt_reg <= '0;
      char_cnt_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      count_reg    <= count_next;
      empty_reg    <= (count_next == '0);
      full_reg     <= (count_next == DEPTH_CNT);
      rx_valid_reg <= good_pend_reg;
      sim_end_reg  <= good_pend_reg && (shift_reg == EOT_CHAR);
      if (good_pend_reg) begin
        rx_char_reg <= shift_reg;
        if (char_cnt_reg != 16'hFFFF) char_cnt_reg <= char_cnt_reg + 16'd1;
      end
      if (push && !push_ok) overflow_reg <= 1'b1;
      if (ferr_hit && (ferr_cnt_reg != 8'hFF)) ferr_cnt_reg <= ferr_cnt_reg + 8'd1;
    end
  end

  assign rd.RD_DATA = empty_reg ? 8'h00 : mem[rd_ptr_reg];
  assign rd.EMPTY   = empty_reg;
  assign rd.FULL    = full_reg;
  assign RX_VALID   = rx_valid_reg;
  assign RX_CHAR    = rx_char_reg;
  assign OVERFLOW   = overflow_reg;
  assign FERR_CNT   = ferr_cnt_reg;
  assign CHAR_CNT   = char_cnt_reg;
  assign SIM_END    = sim_end_reg;
endmodule

// File: tb/tb_tb_shield_uart_capture.sv
// Bench for the shield UART capture block: directed scenarios plus random frames,
// checked every cycle against an event-queue model of frames, counters and FIFO.
module tb_tb_shield_uart_capture;
  localparam int         CPB   = 16;
  localparam int         DEPTH = 8;
  localparam logic [7:0] EOT   = 8'h04;
  localparam int         LAT   = 3 + CPB / 2 + 9 * CPB;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        RXD;
  logic        rx_valid, overflow, sim_end;
  logic [7:0]  rx_char, ferr_cnt;
  logic [15:0] char_cnt;

  tb_shield_uart_capture_if rd_if ();

  tb_shield_uart_capture #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .EOT_CHAR    (EOT)
  ) u_dut (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .RXD     (RXD),
    .rd      (rd_if),
    .RX_VALID(rx_valid),
    .RX_CHAR (rx_char),
    .OVERFLOW(overflow),
    .FERR_CNT(ferr_cnt),
    .CHAR_CNT(char_cnt),
    .SIM_END (sim_end)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    int         at;
    bit         is_ferr;
    logic [7:0] ch;
  } ev_t;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc   = 0;
  int         rd_mode = 0;
  int         pop_at  = -1;
  logic       rst_s = 1'b0;
  logic       rd_s  = 1'b0;
  bit         chk_on = 1'b0;
  ev_t        evq[$];
  logic [7:0] mq[$];
  int         m_char = 0;
  int         m_ferr = 0;
  bit         m_ovf  = 1'b0;
  logic [7:0] m_rxchar = 8'h00;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  always @(posedge HCLK) begin
    cyc   <= cyc + 1;
    rst_s <= HRESET;
    rd_s  <= rd_if.RD_EN;
  end

  // Model: frame outcomes arrive as timed events; FIFO is a plain queue.
  always @(negedge HCLK) begin : model
    ev_t        e;
    bit         exp_v;
    bit         exp_end;
    logic [7:0] exp_head;
    exp_v   = 1'b0;
    exp_end = 1'b0;
    if (rst_s) begin
      chk_on   = 1'b1;
      evq.delete();
      mq.delete();
      m_char   = 0;
      m_ferr   = 0;
      m_ovf    = 1'b0;
      m_rxchar = 8'h00;
    end else begin
      if (rd_s && mq.size() > 0) void'(mq.pop_front());
      while (evq.size() > 0 && evq[0].at <= cyc) begin
        e = evq.pop_front();
        if (e.is_ferr) begin
          if (m_ferr < 255) m_ferr++;
        end else begin
          exp_v    = 1'b1;
          m_rxchar = e.ch;
          if (m_char < 65535) m_char++;
          if (e.ch == EOT)            exp_end = 1'b1;
          else if (mq.size() < DEPTH) mq.push_back(e.ch);
          else                        m_ovf = 1'b1;
        end
      end
    end
    if (chk_on) begin
      exp_head = (mq.size() > 0) ? mq[0] : 8'h00;
      check_eq("rx_valid", 32'(rx_valid), 32'(exp_v));
      check_eq("sim_end",  32'(sim_end),  32'(exp_end));
      check_eq("rx_char",  32'(rx_char),  32'(m_rxchar));
      check_eq("char_cnt", 32'(char_cnt), 32'(m_char));
      check_eq("ferr_cnt", 32'(ferr_cnt), 32'(m_ferr));
      check_eq("overflow", 32'(overflow), 32'(m_ovf));
      check_eq("empty",    32'(rd_if.EMPTY), 32'(mq.size() == 0));
      check_eq("full",     32'(rd_if.FULL),  32'(mq.size() == DEPTH));
      check_eq("rd_data",  32'(rd_if.RD_DATA), 32'(exp_head));
    end
  end

  initial begin
    rd_if.RD_EN = 1'b0;
    forever begin
      @(posedge HCLK);
      #1;
      rd_if.RD_EN = (cyc + 1 == pop_at) || (rd_mode == 2) ||
                    (rd_mode == 1 && $urandom_range(3) == 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    tick(1);
    HRESET = 1'b0;
    tick(2);
  endtask

  task automatic drain();
    rd_mode = 2;
    tick(DEPTH + 4);
    rd_mode = 0;
    tick(2);
  endtask

  // Callers are always 1 time unit past a rising edge, so the start bit
  // is first sampled on the next edge.
  task automatic send_frame(input logic [7:0] b, input bit stop_bit, input bit pop_on_accept);
    ev_t x;
    int  e;
    e         = cyc + 1;
    x.at      = stop_bit ? e + LAT : e + LAT - 1;
    x.is_ferr = !stop_bit;
    x.ch      = b;
    evq.push_back(x);
    if (pop_on_accept) pop_at = e + LAT;
    RXD = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      tick(CPB);
    end
    RXD = stop_bit;
    tick(CPB);
    if (!stop_bit) begin
      RXD = 1'b1;
      tick(CPB);
    end
  endtask

  task automatic break_line(input int bits);
    ev_t x;
    x.at      = cyc + 1 + LAT - 1;
    x.is_ferr = 1'b1;
    x.ch      = 8'h00;
    evq.push_back(x);
    RXD = 1'b0;
    tick(bits * CPB);
    RXD = 1'b1;
    tick(CPB);
  endtask

  initial begin
    logic [7:0] partial;
    int         gap;
    HRESET = 1'b1;
    RXD    = 1'b1;
    tick(3);
    HRESET = 1'b0;
    tick(5);

    send_frame(8'h55, 1'b1, 1'b0);
    tick(4);
    rd_mode = 2;
    tick(2);
    rd_mode = 0;
    tick(2);

    do_reset();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0);
    tick(2);
    drain();

    do_reset();
    for (int i = 0; i < 9; i++) send_frame(8'h30 + 8'(i), 1'b1, 1'b0);
    tick(2);
    send_frame(8'h39, 1'b1, 1'b1);
    tick(2);
    drain();

    do_reset();
    send_frame(8'h41, 1'b0, 1'b0);
    break_line(40);
    send_frame(8'h42, 1'b1, 1'b0);
    drain();

    do_reset();
    RXD = 1'b0;
    tick(3);
    RXD = 1'b1;
    tick(2 * CPB);
    send_frame(EOT, 1'b1, 1'b0);
    tick(4);

    // Reset lands in the middle of the data bits; the line is then released.
    do_reset();
    partial = 8'h7E;
    RXD = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      RXD = partial[i];
      tick(CPB);
    end
    HRESET = 1'b1;
    RXD    = 1'b1;
    tick(1);
    HRESET = 1'b0;
    tick(12 * CPB);
    send_frame(8'h7E, 1'b1, 1'b0);
    drain();

    do_reset();
    rd_mode = 1;
    for (int i = 0; i < 40; i++) begin
      send_frame(8'($urandom), ($urandom_range(7) != 0), 1'b0);
      gap = $urandom_range(20);
      if (gap > 0) tick(gap);
    end
    rd_mode = 0;
    tick(4);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    n_err++;
    $display("FAIL timeout cyc=%0d got=running expected=finished", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "bench time limit reached");
  end
endmodule
